// File: rtl/systolic_pcpi_sequencer.sv
// PCPI front-end sequencer for the 3x3 systolic matrix-multiply array.
// Optional run counter behind SYSTOLIC_PERF_CNT_EN (funct3 011 reads it).
module systolic_pcpi_sequencer #(
    parameter logic [6:0] OPCODE     = 7'b0001011,
    parameter int         RUN_CYCLES = 7,
    parameter int         CFG_DEPTH  = 28
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        cfg_we,
    output logic [4:0]  cfg_addr,
    output logic [15:0] cfg_data,
    output logic        arr_clr,
    output logic        arr_en,
    output logic [2:0]  arr_step,
    output logic        arr_bias_sel,
    input  logic [8:0]  res_bits,
    output logic        busy
);

    localparam logic [2:0] LAST_STEP = 3'(RUN_CYCLES - 1);
    localparam logic [5:0] CFG_LIMIT = 6'(CFG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_CLR, S_RUN, S_RESP, S_REL
    } state_t;

    typedef enum logic [1:0] {
        R_NONE, R_RES, R_CNT
    } resp_t;

    state_t      state_q, state_d;
    resp_t       resp_q, resp_d;
    logic [2:0]  step_q, step_d;
    logic [8:0]  result_q;
    logic [4:0]  cfg_addr_q;
    logic [15:0] cfg_data_q;
    logic        run_done;
    logic        match;
    logic [2:0]  funct3;
    logic        unused_insn;

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] run_cnt;
`endif

    assign match       = pcpi_valid && (pcpi_insn[6:0] == OPCODE);
    assign funct3      = pcpi_insn[14:12];
    assign unused_insn = pcpi_insn[31];
    assign cfg_addr    = cfg_addr_q;
    assign cfg_data    = cfg_data_q;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        resp_d       = resp_q;
        run_done     = 1'b0;
        pcpi_wr      = 1'b0;
        pcpi_rd      = '0;
        pcpi_wait    = 1'b0;
        pcpi_ready   = 1'b0;
        cfg_we       = 1'b0;
        arr_clr      = !resetn;
        arr_en       = 1'b0;
        arr_step     = '0;
        arr_bias_sel = 1'b0;
        busy         = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                step_d = '0;
                resp_d = R_NONE;
                if (match) begin
                    unique case (1'b1)
                        (funct3 == 3'b000): state_d = S_CFG;
                        (funct3 == 3'b101): state_d = S_CLR;
                        (funct3 == 3'b111): state_d = S_RUN;
`ifdef SYSTOLIC_PERF_CNT_EN
                        (funct3 == 3'b011): begin
                            state_d = S_RESP;
                            resp_d  = R_CNT;
                        end
`endif
                        default: state_d = S_RESP;
                    endcase
                end
            end
            S_CFG: begin
                cfg_we  = ({1'b0, cfg_addr_q} < CFG_LIMIT);
                state_d = S_RESP;
            end
            S_CLR: begin
                arr_clr = 1'b1;
                state_d = S_RESP;
            end
            S_RUN: begin
                arr_en       = 1'b1;
                arr_step     = step_q;
                arr_bias_sel = (step_q == '0);
                pcpi_wait    = 1'b1;
                // A dropped request abandons the run; array state is left as-is
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (step_q == LAST_STEP) begin
                    state_d  = S_RESP;
                    resp_d   = R_RES;
                    step_d   = '0;
                    run_done = 1'b1;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_RESP: begin
                pcpi_ready = 1'b1;
                state_d    = S_REL;
                unique case (resp_q)
                    R_RES: begin
                        pcpi_wr = 1'b1;
                        pcpi_rd = {23'b0, result_q};
                    end
`ifdef SYSTOLIC_PERF_CNT_EN
                    R_CNT: begin
                        pcpi_wr = 1'b1;
                        pcpi_rd = run_cnt;
                    end
`endif
                    default: ;
                endcase
            end
            S_REL: begin
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                    resp_d  = R_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            resp_q     <= R_NONE;
            step_q     <= '0;
            result_q   <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            step_q  <= step_d;
            if (state_q == S_IDLE && match) begin
                cfg_addr_q <= pcpi_insn[11:7];
                cfg_data_q <= pcpi_insn[30:15];
            end
            if (state_q == S_CLR) begin
                result_q <= '0;
            end else if (run_done) begin
                result_q <= res_bits;
            end
        end
    end

`ifdef SYSTOLIC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_cnt <= '0;
        end else if (run_done && run_cnt != '1) begin
            run_cnt <= run_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/systolic_pcpi_sequencer.md
Name: systolic_pcpi_sequencer

Overview:
- PCPI front-end controller for the 3x3 systolic matrix-multiply array.
- Decodes custom-0 instructions from the CPU and turns them into array control:
  - writes the operand/bias/threshold config store;
  - clears the array;
  - steps the array through its skewed-feed schedule;
  - latches the 9-bit thresholded result and returns it on the PCPI handshake.
- Sits between the core's PCPI bus and the PE array datapath. Owns all timing; the array itself is purely datapath.

Parameters:
- OPCODE, 7'b0001011, custom opcode matched on pcpi_insn[6:0].
- RUN_CYCLES, 7, array steps per multiply (2*N+1 for N=3); result latched after the last step.
- CFG_DEPTH, 28, number of valid config addresses (0-8 A, 9-17 B, 18-26 bias, 27 threshold).

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- pcpi_valid, input, 1, CPU presents instruction.
- pcpi_insn, input, 32, instruction word.
- pcpi_wr, output, 1, rd write-back enable, qualified by pcpi_ready.
- pcpi_rd, output, 32, write-back data.
- pcpi_wait, output, 1, coprocessor busy, CPU must stall.
- pcpi_ready, output, 1, single-cycle completion strobe.
- cfg_we, output, 1, config-store write strobe.
- cfg_addr, output, 5, config address = insn[11:7].
- cfg_data, output, 16, config data = insn[30:15].
- arr_clr, output, 1, synchronous clear of PE accumulators.
- arr_en, output, 1, array clock-enable for one step.
- arr_step, output, 3, current schedule step; array uses it to select skewed A/B feeds.
- arr_bias_sel, output, 1, PE c_in takes bias instead of feedback (step 0 only).
- res_bits, input, 9, comparator outputs (c >= threshold), row-major, bit0 = C[0][0].
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset (resetn low at a clk edge), from any state including mid-run:
  - state = IDLE;
  - all outputs 0, except pcpi_rd = 0 and arr_step = 0;
  - result register and step counter cleared;
  - arr_clr asserted for the reset cycle.
- Match condition: pcpi_valid && insn[6:0] == OPCODE, evaluated only in IDLE.
- Non-matching insn: no response (ready, wait and wr stay 0); stay in IDLE.
- States: IDLE, CFG, CLR, RUN, RESP, REL.
- IDLE, on match, decode funct3 = insn[14:12]:
  - 000 -> CFG.
  - 101 -> CLR.
  - 111 -> RUN, with step = 0 and pcpi_wait = 1 in the same cycle the state is entered.
  - Any other funct3 -> RESP with wr = 0 (acknowledged no-op, so the CPU does not hang).
- CFG (1 cycle):
  - cfg_we = 1 only if cfg_addr < CFG_DEPTH; otherwise the write is silently dropped.
  - Then RESP with wr = 0.
- CLR (1 cycle): arr_clr = 1; result register cleared; then RESP with wr = 0.
- RUN:
  - arr_en = 1 every cycle; arr_step = step; arr_bias_sel = (step == 0); pcpi_wait = 1.
  - step increments each cycle.
  - When step == RUN_CYCLES-1, the next cycle enters RESP with the latch flag set.
  - Total RUN_CYCLES array enables, exactly.
- RESP (1 cycle):
  - pcpi_ready = 1; pcpi_wait = 0.
  - If entered from RUN: result register = {23'b0, res_bits}, sampled at the RESP edge, i.e. one cycle after the last arr_en. pcpi_wr = 1 and pcpi_rd = the latched result, visible in the same cycle.
  - Otherwise pcpi_wr = 0 and pcpi_rd = 0.
  - Then REL.
- REL: hold until pcpi_valid == 0, then IDLE. This prevents re-executing a still-asserted instruction.
- Latency, start to ready: RUN_CYCLES + 1 cycles after the match cycle. Config/clear/no-op: 2 cycles.
- Abort: pcpi_valid falling while in RUN:
  - go to IDLE immediately;
  - no ready, arr_en drops, result unchanged;
  - the array is not cleared (software must issue a clear).
- pcpi_ready and pcpi_wr are never high outside RESP.
- pcpi_wait is never high in the same cycle as pcpi_ready.

Optional Feature:
- Macro: SYSTOLIC_PERF_CNT_EN.
- Defined:
  - 32-bit run counter increments on each completed RUN (saturating at 0xFFFFFFFF); cleared by reset only, not by funct3 101.
  - funct3 011 goes to RESP with wr = 1 and pcpi_rd = the counter value.
  - Aborted runs are not counted.
- Undefined:
  - No counter logic.
  - funct3 011 is treated as the generic no-op (wr = 0).

Test Plan:
- Reset mid-RUN at step 3 -> next cycle: IDLE, busy = 0, arr_en = 0, arr_clr = 1, pcpi_ready = 0.
- Config: insn = {1'b0, 16'h0005, 3'b000, 5'd4, 7'b0001011} -> one cycle later cfg_we = 1, cfg_addr = 4, cfg_data = 0x0005; ready one cycle after that with wr = 0. Same with address 30 -> cfg_we never asserts, ready still returned.
- Start with res_bits driven to 9'h1A5 -> arr_en high for exactly 7 cycles, arr_step 0..6, arr_bias_sel only at step 0; then pcpi_ready = 1, pcpi_wr = 1, pcpi_rd = 0x000001A5, wait = 0 in that cycle.
- Handshake hold: keep pcpi_valid high 3 cycles after ready -> no second ready, no extra arr_en; returns to IDLE on valid low.
- Abort: drop pcpi_valid at step 2 -> IDLE next cycle, no ready pulse; a subsequent start still yields exactly 7 enables.
- Foreign opcode 7'b0110011 with valid -> no ready, wait or wr ever. Under SYSTOLIC_PERF_CNT_EN: after 2 completed runs plus 1 aborted run, funct3 011 returns pcpi_rd = 2.
